// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: one single-port memory shared by the fetch unit and the program loader.
// The loader owns the memory in BOOT. In RUN the two requesters share it round-robin.
module imem_arbiter #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        f_req_i,
    input  logic [31:0] f_addr_i,
    output logic        f_ack_o,
    output logic [31:0] f_data_o,
    output logic        f_err_o,
    input  logic        l_req_i,
    input  logic        l_we_i,
    input  logic [31:0] l_addr_i,
    input  logic [31:0] l_wdata_i,
    input  logic        l_done_i,
    output logic        l_ack_o,
    output logic [31:0] l_data_o,
    output logic        l_err_o,
    output logic [4:0]  mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        run_o
);
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state_q, state_d;
    logic        last_f_q, last_f_d;
    logic        f_ack_q, f_ack_d;
    logic        f_err_q, f_err_d;
    logic [31:0] f_data_q, f_data_d;
    logic        l_ack_q, l_ack_d;
    logic        l_err_q, l_err_d;
    logic [31:0] l_data_q, l_data_d;

    logic        f_elig, l_elig, gnt_f, gnt_l, fault;
    logic [31:0] sel_addr;
    logic [4:0]  mem_addr_c;
    logic        mem_we_c;
    logic [31:0] mem_wdata_c;

    always_comb begin
        f_elig   = f_req_i && !f_ack_q && (state_q == RUN);
        l_elig   = l_req_i && !l_ack_q;
        // On contention, fetch wins only if the loader had the last grant.
        gnt_f    = f_elig && (!l_elig || !last_f_q);
        gnt_l    = l_elig && !gnt_f;
        sel_addr = gnt_f ? f_addr_i : l_addr_i;
        fault    = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= ADDR_LIMIT);

        mem_addr_c  = 5'd0;
        mem_we_c    = 1'b0;
        mem_wdata_c = 32'd0;
        if (gnt_f || gnt_l) begin
            mem_addr_c = sel_addr[6:2];
        end
        if (gnt_l) begin
            mem_we_c    = l_we_i && !fault;
            mem_wdata_c = l_wdata_i;
        end

        f_ack_d  = gnt_f;
        f_err_d  = gnt_f && fault;
        f_data_d = (gnt_f && !fault) ? mem_rdata_i : 32'd0;
        l_ack_d  = gnt_l;
        l_err_d  = gnt_l && fault;
        l_data_d = (gnt_l && !fault && !l_we_i) ? mem_rdata_i : 32'd0;

        last_f_d = last_f_q;
        if (gnt_f) begin
            last_f_d = 1'b1;
        end else if (gnt_l) begin
            last_f_d = 1'b0;
        end

        state_d = state_q;
        if (state_q == BOOT && l_done_i) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= BOOT;
            last_f_q <= 1'b0;
            f_ack_q  <= 1'b0;
            f_err_q  <= 1'b0;
            f_data_q <= 32'd0;
            l_ack_q  <= 1'b0;
            l_err_q  <= 1'b0;
            l_data_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            last_f_q <= last_f_d;
            f_ack_q  <= f_ack_d;
            f_err_q  <= f_err_d;
            f_data_q <= f_data_d;
            l_ack_q  <= l_ack_d;
            l_err_q  <= l_err_d;
            l_data_q <= l_data_d;
        end
    end

    // Reset masks every output immediately, including completions left over from before reset.
    always_comb begin
        f_ack_o     = f_ack_q && !rst_i;
        f_err_o     = f_err_q && !rst_i;
        f_data_o    = rst_i ? 32'd0 : f_data_q;
        l_ack_o     = l_ack_q && !rst_i;
        l_err_o     = l_err_q && !rst_i;
        l_data_o    = rst_i ? 32'd0 : l_data_q;
        mem_addr_o  = rst_i ? 5'd0 : mem_addr_c;
        mem_we_o    = mem_we_c && !rst_i;
        mem_wdata_o = rst_i ? 32'd0 : mem_wdata_c;
        run_o       = (state_q == RUN) && !rst_i;
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: expected acks are queued when requests are driven and popped on ack.
module tb_imem_arbiter;
    typedef struct packed {
        logic        is_f;
        logic [31:0] data;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0, l_req = 1'b0, l_we = 1'b0, l_done = 1'b0;
    logic [31:0] f_addr = 32'd0, l_addr = 32'd0, l_wdata = 32'd0;
    logic        f_ack, f_err, l_ack, l_err, mem_we, run;
    logic [31:0] f_data, l_data, mem_wdata, mem_rdata;
    logic [4:0]  mem_addr;

    logic [31:0] mem [0:31];
    logic [31:0] cyc = 32'd0;
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;

    imem_arbiter #(.MEM_WORDS(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .f_req_i(f_req), .f_addr_i(f_addr), .f_ack_o(f_ack), .f_data_o(f_data), .f_err_o(f_err),
        .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata), .l_done_i(l_done),
        .l_ack_o(l_ack), .l_data_o(l_data), .l_err_o(l_err),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .run_o(run)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 32'd1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic push(input logic is_f, input logic [31:0] data, input logic err, input logic [31:0] at);
        exp_t e;
        e.is_f = is_f; e.data = data; e.err = err; e.cyc = at;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (f_ack && l_ack) chk("double_ack", 32'd1, 32'd0);
        if (!f_ack && (f_data != 32'd0 || f_err)) chk("f_hold_zero", {f_err, f_data[30:0]}, 32'd0);
        if (!l_ack && (l_data != 32'd0 || l_err)) chk("l_hold_zero", {l_err, l_data[30:0]}, 32'd0);
        if (f_ack || l_ack) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", {31'd0, f_ack}, {31'd0, l_ack & ~l_ack});
                chk("spurious_ack_any", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_who_f", {31'd0, f_ack}, {31'd0, e.is_f});
                chk("ack_data", e.is_f ? f_data : l_data, e.data);
                chk("ack_err", {31'd0, e.is_f ? f_err : l_err}, {31'd0, e.err});
                chk("ack_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_ack(input logic is_f);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (is_f ? f_ack : l_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk(is_f ? "f_ack_timeout" : "l_ack_timeout", 32'd0, 32'd1);
        if (is_f) f_req = 1'b0;
        else l_req = 1'b0;
    endtask

    task automatic l_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] a;
        @(posedge clk); #1;
        l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wd;
        push(1'b0, exp_d, exp_e, cyc + 32'd1);
        @(negedge clk);
        a = addr;
        chk("l_mem_we", {31'd0, mem_we}, {31'd0, we & ~exp_e});
        chk("l_mem_addr", {27'd0, mem_addr}, {27'd0, a[6:2]});
        if (we && !exp_e) chk("l_mem_wdata", mem_wdata, wd);
        wait_ack(1'b0);
    endtask

    task automatic f_access(input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] a;
        @(posedge clk); #1;
        f_req = 1'b1; f_addr = addr;
        push(1'b1, exp_d, exp_e, cyc + 32'd1);
        @(negedge clk);
        a = addr;
        chk("f_mem_we", {31'd0, mem_we}, 32'd0);
        chk("f_mem_addr", {27'd0, mem_addr}, {27'd0, a[6:2]});
        wait_ack(1'b1);
    endtask

    initial begin
        logic [31:0] k;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;

        // Reset state
        @(negedge clk);
        chk("rst_run", {31'd0, run}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_acks", {30'd0, f_ack, l_ack}, 32'd0);
        chk("post_rst_run", {31'd0, run}, 32'd0);
        chk("post_rst_mem", {26'd0, mem_addr, mem_we}, 32'd0);

        // Boot load with a fetch waiting the whole time
        @(posedge clk); #1;
        f_req = 1'b1; f_addr = 32'h0;
        l_access(1'b1, 32'h0,  32'h20080005, 32'h0, 1'b0);
        l_access(1'b1, 32'h4,  32'hDEADBEEF, 32'h0, 1'b0);
        l_access(1'b1, 32'h7C, 32'h12345678, 32'h0, 1'b0);
        l_access(1'b0, 32'h4,  32'h0, 32'hDEADBEEF, 1'b0);
        l_access(1'b1, 32'h80, 32'hFFFFFFFF, 32'h0, 1'b1);
        l_access(1'b0, 32'h1,  32'h0, 32'h0, 1'b1);
        chk("boot_run", {31'd0, run}, 32'd0);

        // l_done together with a loader write; the waiting fetch goes next cycle
        @(posedge clk); #1;
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h8; l_wdata = 32'hCAFEF00D; l_done = 1'b1;
        k = cyc;
        push(1'b0, 32'h0, 1'b0, k + 32'd1);
        push(1'b1, 32'h20080005, 1'b0, k + 32'd2);
        @(negedge clk);
        chk("done_mem_we", {31'd0, mem_we}, 32'd1);
        chk("done_run_before", {31'd0, run}, 32'd0);
        @(posedge clk); #1;
        l_done = 1'b0; l_req = 1'b0;
        chk("done_run_after", {31'd0, run}, 32'd1);
        wait_ack(1'b1);

        // RUN-mode fetches including boundaries and faults
        f_access(32'h8,  32'hCAFEF00D, 1'b0);
        f_access(32'h2,  32'h0, 1'b1);
        f_access(32'h7C, 32'h12345678, 1'b0);
        f_access(32'h80, 32'h0, 1'b1);
        l_access(1'b0, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0);

        // Contention right after reset: F,L,F,L... one grant per cycle
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 l_done = 1'b1;
        @(posedge clk); #1 l_done = 1'b0;
        f_req = 1'b1; f_addr = 32'h4;
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'h7C;
        k = cyc;
        for (int i = 0; i < 8; i++)
            push(i % 2 == 0, (i % 2 == 0) ? 32'hDEADBEEF : 32'h12345678, 1'b0, k + 32'(i + 1));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            l_done = (i == 2);
        end
        f_req = 1'b0; l_req = 1'b0; l_done = 1'b0;
        chk("run_ignores_done", {31'd0, run}, 32'd1);
        repeat (2) @(posedge clk);
        #1 chk("sb_empty_contention", 32'(sb.size()), 32'd0);

        // Reset in a grant cycle
        @(posedge clk); #1;
        rst = 1'b1; f_req = 1'b1; f_addr = 32'h4;
        @(negedge clk);
        chk("rst_grant_run", {31'd0, run}, 32'd0);
        chk("rst_grant_mem_addr", {27'd0, mem_addr}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_grant_no_ack", {31'd0, f_ack}, 32'd0);
        chk("rst_grant_run_after", {31'd0, run}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("boot_fetch_blocked", {31'd0, f_ack}, 32'd0);
        end
        @(posedge clk); #1;
        l_done = 1'b1;
        k = cyc;
        push(1'b1, 32'hDEADBEEF, 1'b0, k + 32'd2);
        @(posedge clk); #1 l_done = 1'b0;
        wait_ack(1'b1);

        repeat (2) @(posedge clk);
        #1 chk("sb_empty_final", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
